// File: rtl/stacker_pkg.sv
// stacker_pkg: shared types and default constants for the stacker sequencer.
//   state_t        - sequencer FSM states (IDLE, RUN, SETTLE, OVER)
//   DB_CYCLES      - default debounce hold time, in clk cycles
//   BASE_DIV       - default move-tick period at height 0
//   DIV_STEP       - default period reduction per stack level
//   MIN_DIV        - default floor on the move-tick period
//   SETTLE_CYCLES  - cycles the datapath needs after a placement (UPDATE/CHECK)
package stacker_pkg;

  localparam int unsigned DB_CYCLES     = 500000;
  localparam int unsigned BASE_DIV      = 2000000;
  localparam int unsigned DIV_STEP      = 150000;
  localparam int unsigned MIN_DIV       = 400000;
  localparam int unsigned SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2,
    OVER   = 2'd3
  } state_t;

endpackage

// File: rtl/stacker_sequencer_btn_debounce.sv
// btn_debounce: synchronizes a raw button level, accepts a new level only after
// it has been stable for DB_CYCLES consecutive cycles, and emits a one-cycle
// pulse on every accepted 0->1 transition.
//   clk   - clock
//   rst   - asynchronous active-high reset
//   in    - raw button level, asynchronous to clk
//   pulse - one-cycle pulse per accepted press
module btn_debounce #(
  parameter int unsigned DB_CYCLES = stacker_pkg::DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic [1:0]  sync_reg;
  logic        level_reg;
  logic        pulse_reg;
  logic [31:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 2'b00;
      level_reg <= 1'b0;
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], in};
      pulse_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        // Level agrees with the accepted one: any partial count is abandoned.
        cnt_reg <= '0;
      end else if (cnt_reg == DB_CYCLES - 32'd1) begin
        // This is the DB_CYCLES-th consecutive cycle at the new level.
        level_reg <= sync_reg[1];
        pulse_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/stacker_sequencer.sv
// stacker_sequencer: game sequencer for the block stacker. Debounces the centre
// button, runs the IDLE/RUN/SETTLE/OVER state machine and produces the move-tick
// that advances the moving block, with a period that shrinks as the stack grows.
//   clk       - clock
//   rst       - asynchronous active-high reset
//   btn_raw   - raw centre-button level
//   height    - current stack height (0..10) from the datapath
//   game_over - level-high when the datapath has ended the game
//   move_tick - one-cycle pulse advancing the moving block (RUN only)
//   place     - one-cycle pulse per debounced press (every state)
//   running   - high while in RUN
//   cur_div   - move-tick period currently in force
// Build option: define STACKER_SPEEDUP_EN to make the period depend on height;
// otherwise the period is fixed at BASE_DIV.
module stacker_sequencer #(
  parameter int unsigned DB_CYCLES = stacker_pkg::DB_CYCLES,
  parameter int unsigned BASE_DIV  = stacker_pkg::BASE_DIV,
  parameter int unsigned DIV_STEP  = stacker_pkg::DIV_STEP,
  parameter int unsigned MIN_DIV   = stacker_pkg::MIN_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [4:0]  height,
  input  logic        game_over,
  output logic        move_tick,
  output logic        place,
  output logic        running,
  output logic [31:0] cur_div
);

  import stacker_pkg::*;

  state_t      state_reg, state_next;
  logic [31:0] div_cnt_reg;
  logic [31:0] cur_div_reg;
  logic [31:0] target_div;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .in   (btn_raw),
    .pulse(place)
  );

`ifdef STACKER_SPEEDUP_EN
  logic [31:0] step_prod;

  // Saturate at MIN_DIV without ever letting the subtraction wrap.
  always_comb begin
    step_prod = 32'(height) * DIV_STEP;
    if (step_prod >= BASE_DIV) begin
      target_div = MIN_DIV;
    end else if ((BASE_DIV - step_prod) < MIN_DIV) begin
      target_div = MIN_DIV;
    end else begin
      target_div = BASE_DIV - step_prod;
    end
  end
`else
  logic [31:0] unused_cfg;

  assign target_div = BASE_DIV;
  assign unused_cfg = DIV_STEP ^ MIN_DIV ^ {27'd0, height};
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. In RUN, game_over takes priority over a simultaneous press.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (place) state_next = RUN;
      RUN: begin
        if (game_over)  state_next = OVER;
        else if (place) state_next = SETTLE;
      end
      SETTLE: begin
        if (div_cnt_reg == SETTLE_CYCLES - 32'd1) begin
          state_next = game_over ? OVER : RUN;
        end
      end
      OVER:    if (place) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    running   = (state_reg == RUN);
    move_tick = (state_reg == RUN) && (div_cnt_reg == cur_div_reg - 32'd1);
    cur_div   = cur_div_reg;
  end

  // Shared counter: the move divider in RUN, the settle timer in SETTLE.
  // The period is only re-sampled at a wrap or on entry to RUN, so a height
  // change never cuts short a period that is already running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      cur_div_reg <= BASE_DIV;
    end else if (state_next != state_reg) begin
      div_cnt_reg <= '0;
      if (state_next == RUN) begin
        cur_div_reg <= target_div;
      end
    end else if (state_reg == RUN) begin
      if (move_tick) begin
        div_cnt_reg <= '0;
        cur_div_reg <= target_div;
      end else begin
        div_cnt_reg <= div_cnt_reg + 32'd1;
      end
    end else if (state_reg == SETTLE) begin
      div_cnt_reg <= div_cnt_reg + 32'd1;
    end else begin
      div_cnt_reg <= '0;
    end
  end

endmodule

// File: tb/tb_stacker_sequencer.sv
// tb_stacker_sequencer: scoreboard bench for stacker_sequencer with small
// parameters. Expected tick and place cycles are queued as stimulus is driven
// and matched by negedge monitors when the DUT produces them.
module tb_stacker_sequencer;

  localparam int DB   = 4;
  localparam int BASE = 10;
  localparam int STEP = 2;
  localparam int MINP = 4;

`ifdef STACKER_SPEEDUP_EN
  localparam int PER_H0 = 10;
  localparam int PER_H2 = 6;
  localparam int PER_H5 = 4;
`else
  localparam int PER_H0 = 10;
  localparam int PER_H2 = 10;
  localparam int PER_H5 = 10;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_raw;
  logic [4:0]  height;
  logic        game_over;
  logic        move_tick;
  logic        place;
  logic        running;
  logic [31:0] cur_div;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tick_q[$];
  int place_q[$];
  int tick_exp;
  int place_exp;

  stacker_sequencer #(
    .DB_CYCLES(DB),
    .BASE_DIV (BASE),
    .DIV_STEP (STEP),
    .MIN_DIV  (MINP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .height   (height),
    .game_over(game_over),
    .move_tick(move_tick),
    .place    (place),
    .running  (running),
    .cur_div  (cur_div)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick scoreboard.
  always @(negedge clk) begin
    if (move_tick) begin
      if (tick_q.size() == 0) begin
        check("tick_unexpected", 32'(move_tick), 32'd0);
      end else begin
        tick_exp = tick_q.pop_front();
        $display("move_tick at cycle %0d (expected %0d)", cyc, tick_exp);
        check("tick_cycle", 32'(cyc), 32'(tick_exp));
      end
    end else if (tick_q.size() != 0 && tick_q[0] <= cyc) begin
      tick_exp = tick_q.pop_front();
      check("tick_missing", 32'(move_tick), 32'd1);
    end
  end

  // Place scoreboard.
  always @(negedge clk) begin
    if (place) begin
      if (place_q.size() == 0) begin
        check("place_unexpected", 32'(place), 32'd0);
      end else begin
        place_exp = place_q.pop_front();
        $display("place at cycle %0d (expected %0d)", cyc, place_exp);
        check("place_cycle", 32'(cyc), 32'(place_exp));
      end
    end else if (place_q.size() != 0 && place_q[0] <= cyc) begin
      place_exp = place_q.pop_front();
      check("place_missing", 32'(place), 32'd1);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, p1, t1, t2, t3, t5, p_s, t_a, t_b, p_g, d_o, p_o, d_r, p_r, d_f, p_f;

    rst = 1'b1; btn_raw = 1'b0; height = 5'd0; game_over = 1'b0;
    step(3);
    check("rst_move_tick", 32'(move_tick), 32'd0);
    check("rst_place", 32'(place), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_cur_div", cur_div, 32'(BASE));
    rst = 1'b0;
    step(2);

    // Chatter that never stays put for DB cycles, then a clean hold.
    for (int i = 0; i < 6; i++) begin
      btn_raw = ~btn_raw;
      step(2);
    end
    t0 = cyc;
    btn_raw = 1'b1;
    p1 = t0 + 2 + DB;
    place_q.push_back(p1);
    check("idle_after_chatter", 32'(running), 32'd0);

    wait_to(p1 + 1);
    check("run_entry", 32'(running), 32'd1);
    check("div_h0", cur_div, 32'(PER_H0));
    t1 = p1 + PER_H0;
    t2 = t1 + PER_H0;
    tick_q.push_back(t1);
    tick_q.push_back(t2);

    wait_to(t0 + 10);
    btn_raw = 1'b0;

    // Height rises mid-period: the running period must not shrink.
    wait_to(p1 + 12);
    height = 5'd2;
    wait_to(p1 + 13);
    check("div_hold", cur_div, 32'(PER_H0));

    wait_to(t2 + 2);
    check("div_h2", cur_div, 32'(PER_H2));
    height = 5'd5;
    t3  = t2 + PER_H2;
    t5  = t3 + 2 * PER_H5;
    p_s = t5 + 2 * PER_H5;
    tick_q.push_back(t3);
    tick_q.push_back(t3 + PER_H5);
    tick_q.push_back(t5);
    tick_q.push_back(t5 + PER_H5);
    tick_q.push_back(p_s);
    wait_to(t3 + 1);
    check("div_h5_floor", cur_div, 32'(PER_H5));

    // Press landing on a tick cycle: both pulses, then two quiet settle cycles.
    wait_to(p_s - DB - 2);
    btn_raw = 1'b1;
    place_q.push_back(p_s);
    wait_to(p_s);
    btn_raw = 1'b0;
    wait_to(p_s + 1);
    check("settle1_running", 32'(running), 32'd0);
    t_a = p_s + 2 + PER_H5;
    t_b = t_a + 2 * PER_H5;
    tick_q.push_back(t_a);
    tick_q.push_back(t_a + PER_H5);
    tick_q.push_back(t_b);
    wait_to(p_s + 2);
    check("settle2_running", 32'(running), 32'd0);
    wait_to(p_s + 3);
    check("settle_exit_running", 32'(running), 32'd1);

    // game_over and place in the same RUN cycle.
    p_g = t_b + 3;
    wait_to(p_g - DB - 2);
    btn_raw = 1'b1;
    place_q.push_back(p_g);
    wait_to(p_g);
    game_over = 1'b1;
    btn_raw = 1'b0;
    wait_to(p_g + 1);
    check("over_running", 32'(running), 32'd0);
    wait_to(p_g + 3);
    check("over_stays", 32'(running), 32'd0);

    // Press in OVER returns to IDLE; a second press then starts RUN again.
    d_o = p_g + 2 * BASE;
    wait_to(d_o);
    btn_raw = 1'b1;
    p_o = d_o + 2 + DB;
    place_q.push_back(p_o);
    wait_to(p_o);
    btn_raw = 1'b0;
    wait_to(p_o + 1);
    check("idle_after_over", 32'(running), 32'd0);
    game_over = 1'b0;
    height = 5'd0;

    d_r = p_o + 10;
    wait_to(d_r);
    btn_raw = 1'b1;
    p_r = d_r + 2 + DB;
    place_q.push_back(p_r);
    wait_to(p_r);
    btn_raw = 1'b0;
    wait_to(p_r + 1);
    check("run_again", 32'(running), 32'd1);
    check("div_h0_again", cur_div, 32'(PER_H0));

    // Reset with the divider at 7: the pending tick at p_r+10 must never appear.
    wait_to(p_r + 8);
    check("run_before_rst", 32'(running), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_move_tick", 32'(move_tick), 32'd0);
    check("midrst_place", 32'(place), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_cur_div", cur_div, 32'(BASE));
    step(3);
    rst = 1'b0;
    step(30);
    check("idle_after_rst", 32'(running), 32'd0);

    // First press after reset needs the full debounce time.
    d_f = cyc;
    btn_raw = 1'b1;
    p_f = d_f + 2 + DB;
    place_q.push_back(p_f);
    tick_q.push_back(p_f + PER_H0);
    wait_to(p_f);
    btn_raw = 1'b0;
    wait_to(p_f + PER_H0 + 2);

    check("tick_q_drained", 32'(tick_q.size()), 32'd0);
    check("place_q_drained", 32'(place_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
